main_control_fsm: RTL
=====================

MAIN_CONTROL_FSM -- requirements
Module: main_control_fsm

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; clk and rst SHALL be listed first.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 Op  input  6  instruction opcode from the instruction register.
REQ-005 mem_ready  input  1  memory access complete this cycle.
REQ-006 Outputs, 1 bit each, active-high: IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, Branch, PCWrite.
REQ-007 ALUSrcB  output  2  00 = reg B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate shifted left by 2.
REQ-008 ALUOp  output  2  to the ALU decoder: 00 = add, 01 = subtract, 10 = decode by Funct.
REQ-009 PCSrc  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-010 illegal_op  output  1  unsupported opcode detected.
REQ-011 state  output  4  current state, for debug.

Function
REQ-012 Multicycle Moore FSM, except for the mem_ready gating in REQ-014/017/018; any output not listed for a state SHALL be 0.
REQ-013 State codes: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JUMP=11; codes 12-15 SHALL go to FETCH on the next clock.
REQ-014 FETCH: ALUSrcB=01, ALUOp=00, PCSrc=00; IRWrite=PCWrite=mem_ready; stay while mem_ready=0, else go to DECODE.
REQ-015 DECODE: ALUSrcB=11, ALUOp=00; next state by Op: 100011/101011 -> MEMADR, 000000 -> EXECUTE, 000100 -> BRANCH, 001000 -> ADDIEXEC, 000010 -> JUMP.
REQ-016 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; Op=100011 -> MEMREAD, otherwise -> MEMWRITE.
REQ-017 MEMREAD: IorD=1; stay while mem_ready=0, else go to MEMWB.
REQ-018 MEMWRITE: IorD=1, MemWrite=1 for every cycle in the state; stay while mem_ready=0, else go to FETCH.
REQ-019 MEMWB: RegDst=0, MemtoReg=1, RegWrite=1 -> FETCH.
REQ-020 EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> ALUWB; ALUWB: RegDst=1, RegWrite=1 -> FETCH.
REQ-021 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1 -> FETCH.
REQ-022 ADDIEXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> ADDIWB; ADDIWB: RegWrite=1 -> FETCH.
REQ-023 JUMP: PCSrc=10, PCWrite=1 -> FETCH.
REQ-024 Unsupported Op in DECODE: illegal_op=1 for that DECODE cycle, next state FETCH, no write strobe asserted.
REQ-025 Instruction cycle counts with mem_ready held at 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.

Reset
REQ-026 rst=1 SHALL force state=FETCH immediately, without waiting for clk, including mid-instruction and during a memory wait.
REQ-027 While rst=1, all write strobes (IRWrite, PCWrite, MemWrite, RegWrite) SHALL be 0, overriding the FETCH decode.
REQ-028 On the first clk edge after rst deasserts, the block SHALL perform a normal FETCH.

Configuration
REQ-029 Macro MAIN_CONTROL_JUMP_EN defined: Op=000010 SHALL be supported through the JUMP state.
REQ-030 Macro MAIN_CONTROL_JUMP_EN undefined: the JUMP state SHALL not exist; Op=000010 SHALL be handled as illegal per REQ-024; PCSrc SHALL never be 10.

Verification
REQ-031 Reset pulse mid-MEMREAD -> state=0 asynchronously; RegWrite never asserted.
REQ-032 Op=100011, mem_ready=1 -> states 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4.
REQ-033 Op=101011, mem_ready low for 3 cycles in MEMWRITE -> MemWrite=1 for 4 cycles, then state=0.
REQ-034 Op=000000 -> ALUOp=10 in EXECUTE; Op=000100 -> ALUOp=01, Branch=1, PCSrc=01 in BRANCH.
REQ-035 Op=111111 -> illegal_op=1 in DECODE, next state=0, no strobes asserted.
REQ-036 Op=000010 with macro defined -> PCSrc=10, PCWrite=1 in state 11; macro undefined -> illegal_op=1.

Source files
------------

// File: rtl/main_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : main_control_fsm
//  Description : Multicycle processor main control FSM. Moore outputs
//                decoded from the current state; the FETCH, MEMREAD and
//                MEMWRITE states additionally wait on mem_ready. Write
//                strobes are forced low while rst is asserted.
//  Config      : MAIN_CONTROL_JUMP_EN - when defined, Op=000010 (j) is
//                executed through the JUMP state; otherwise it is illegal.
//  Revision    : 1.0 - initial release
// ============================================================================
module main_control_fsm (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] Op,
   input  logic       mem_ready,
   output logic       IorD,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegDst,
   output logic       MemtoReg,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic       Branch,
   output logic       PCWrite,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [1:0] PCSrc,
   output logic       illegal_op,
   output logic [3:0] state
);

   // State encoding
   localparam logic [3:0] c_fetch    = 4'd0;
   localparam logic [3:0] c_decode   = 4'd1;
   localparam logic [3:0] c_memadr   = 4'd2;
   localparam logic [3:0] c_memread  = 4'd3;
   localparam logic [3:0] c_memwb    = 4'd4;
   localparam logic [3:0] c_memwrite = 4'd5;
   localparam logic [3:0] c_execute  = 4'd6;
   localparam logic [3:0] c_aluwb    = 4'd7;
   localparam logic [3:0] c_branch   = 4'd8;
   localparam logic [3:0] c_addiexec = 4'd9;
   localparam logic [3:0] c_addiwb   = 4'd10;
`ifdef MAIN_CONTROL_JUMP_EN
   localparam logic [3:0] c_jump     = 4'd11;
`endif

   // Opcodes
   localparam logic [5:0] c_op_lw    = 6'b100011;
   localparam logic [5:0] c_op_sw    = 6'b101011;
   localparam logic [5:0] c_op_rtype = 6'b000000;
   localparam logic [5:0] c_op_beq   = 6'b000100;
   localparam logic [5:0] c_op_addi  = 6'b001000;
`ifdef MAIN_CONTROL_JUMP_EN
   localparam logic [5:0] c_op_j     = 6'b000010;
`endif

   logic [3:0] r_state;
   logic [3:0] w_next;

   // Raw (pre-reset-gating) write strobes
   logic w_irwrite;
   logic w_pcwrite;
   logic w_memwrite;
   logic w_regwrite;

   // State register; reset returns to FETCH without waiting for a clock
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= c_fetch;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state decode; unused codes fall back to FETCH
   always_comb begin
      w_next = c_fetch;
      case (r_state)
         c_fetch:    w_next = mem_ready ? c_decode : c_fetch;
         c_decode: begin
            case (Op)
               c_op_lw,
               c_op_sw:    w_next = c_memadr;
               c_op_rtype: w_next = c_execute;
               c_op_beq:   w_next = c_branch;
               c_op_addi:  w_next = c_addiexec;
`ifdef MAIN_CONTROL_JUMP_EN
               c_op_j:     w_next = c_jump;
`endif
               default:    w_next = c_fetch;
            endcase
         end
         c_memadr:   w_next = (Op == c_op_lw) ? c_memread : c_memwrite;
         c_memread:  w_next = mem_ready ? c_memwb : c_memread;
         c_memwb:    w_next = c_fetch;
         c_memwrite: w_next = mem_ready ? c_fetch : c_memwrite;
         c_execute:  w_next = c_aluwb;
         c_aluwb:    w_next = c_fetch;
         c_branch:   w_next = c_fetch;
         c_addiexec: w_next = c_addiwb;
         c_addiwb:   w_next = c_fetch;
`ifdef MAIN_CONTROL_JUMP_EN
         c_jump:     w_next = c_fetch;
`endif
         default:    w_next = c_fetch;
      endcase
   end

   // Per-state control decode; anything not set for a state stays 0
   always_comb begin
      IorD       = 1'b0;
      w_memwrite = 1'b0;
      w_irwrite  = 1'b0;
      RegDst     = 1'b0;
      MemtoReg   = 1'b0;
      w_regwrite = 1'b0;
      ALUSrcA    = 1'b0;
      Branch     = 1'b0;
      w_pcwrite  = 1'b0;
      ALUSrcB    = 2'b00;
      ALUOp      = 2'b00;
      PCSrc      = 2'b00;
      illegal_op = 1'b0;
      case (r_state)
         c_fetch: begin
            ALUSrcB   = 2'b01;
            w_irwrite = mem_ready;
            w_pcwrite = mem_ready;
         end
         c_decode: begin
            ALUSrcB = 2'b11;
            case (Op)
               c_op_lw,
               c_op_sw,
               c_op_rtype,
               c_op_beq,
`ifdef MAIN_CONTROL_JUMP_EN
               c_op_j,
`endif
               c_op_addi:  illegal_op = 1'b0;
               default:    illegal_op = 1'b1;
            endcase
         end
         c_memadr: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         c_memread: begin
            IorD = 1'b1;
         end
         c_memwb: begin
            MemtoReg   = 1'b1;
            w_regwrite = 1'b1;
         end
         c_memwrite: begin
            IorD       = 1'b1;
            w_memwrite = 1'b1;
         end
         c_execute: begin
            ALUSrcA = 1'b1;
            ALUOp   = 2'b10;
         end
         c_aluwb: begin
            RegDst     = 1'b1;
            w_regwrite = 1'b1;
         end
         c_branch: begin
            ALUSrcA = 1'b1;
            ALUOp   = 2'b01;
            PCSrc   = 2'b01;
            Branch  = 1'b1;
         end
         c_addiexec: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         c_addiwb: begin
            w_regwrite = 1'b1;
         end
`ifdef MAIN_CONTROL_JUMP_EN
         c_jump: begin
            PCSrc     = 2'b10;
            w_pcwrite = 1'b1;
         end
`endif
         default: begin
            illegal_op = 1'b0;
         end
      endcase
   end

   // Write strobes are held off for as long as reset is asserted
   assign IRWrite  = w_irwrite  & ~rst;
   assign PCWrite  = w_pcwrite  & ~rst;
   assign MemWrite = w_memwrite & ~rst;
   assign RegWrite = w_regwrite & ~rst;

   assign state = r_state;

endmodule
`default_nettype wire
